// File: rtl/poly_voice_manager.sv
// Voice allocator (lowest free voice, else steal the least-recently-loaded or drop) plus a two-stage mixer.
// Load strobes 1 cycle after a request, mixed sample 2 cycles after a ready strobe; no backpressure, a request or ready may arrive every cycle.
module poly_voice_manager #(
  parameter int NUM_VOICES   = 4,
  parameter int SAMPLE_WIDTH = 16,
  parameter int NOTE_WIDTH   = 6,
  parameter int DUR_WIDTH    = 6,
  parameter int STEAL_ENABLE = 1,
  parameter int MIX_MODE     = 0
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 load_new_note,
  input  logic [NOTE_WIDTH-1:0]                note_to_load,
  input  logic [DUR_WIDTH-1:0]                 duration_to_load,
  input  logic [NUM_VOICES-1:0]                voice_playing,
  input  logic [NUM_VOICES*SAMPLE_WIDTH-1:0]   voice_sample,
  input  logic [NUM_VOICES-1:0]                voice_sample_ready,
  output logic [NUM_VOICES-1:0]                voice_load,
  output logic [NOTE_WIDTH-1:0]                voice_note,
  output logic [DUR_WIDTH-1:0]                 voice_duration,
  output logic                                 note_stolen,
  output logic                                 note_dropped,
  output logic [$clog2(NUM_VOICES+1)-1:0]      active_voices,
  output logic [SAMPLE_WIDTH-1:0]              sample_out,
  output logic                                 new_sample_ready
);

  localparam int VW    = $clog2(NUM_VOICES);
  localparam int AW    = $clog2(NUM_VOICES + 1);
  localparam int ACC_W = SAMPLE_WIDTH + VW;
  localparam logic signed [ACC_W-1:0] SAT_HI = {{(VW + 1){1'b0}}, {(SAMPLE_WIDTH - 1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_LO = ~SAT_HI;

  // Reservation covers the gap between our strobe and the player raising voice_playing.
  logic [1:0]            res_cnt [NUM_VOICES];
  logic [VW-1:0]         rank    [NUM_VOICES];
  logic [NUM_VOICES-1:0] reserved;
  logic [NUM_VOICES-1:0] busy;
  logic                  has_free;
  logic [VW-1:0]         free_idx;
  logic [VW-1:0]         lru_idx;
  logic [VW-1:0]         pick_idx;
  logic                  pick_vld;
  logic [NUM_VOICES-1:0] pick_onehot;

  always_comb begin
    for (int i = 0; i < NUM_VOICES; i++) begin
      reserved[i] = (res_cnt[i] != 2'd0);
    end
  end

  assign busy = voice_playing | reserved;

  always_comb begin
    has_free    = 1'b0;
    free_idx    = '0;
    lru_idx     = '0;
    pick_onehot = '0;
    for (int i = NUM_VOICES - 1; i >= 0; i--) begin
      if (!busy[i]) begin
        has_free = 1'b1;
        free_idx = VW'(i);
      end
      if (rank[i] == VW'(NUM_VOICES - 1)) begin
        lru_idx = VW'(i);
      end
    end
    pick_idx = has_free ? free_idx : lru_idx;
    pick_vld = load_new_note && (has_free || (STEAL_ENABLE != 0));
    if (pick_vld) begin
      pick_onehot[pick_idx] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      voice_load     <= '0;
      voice_note     <= '0;
      voice_duration <= '0;
      note_stolen    <= 1'b0;
      note_dropped   <= 1'b0;
      active_voices  <= '0;
      for (int i = 0; i < NUM_VOICES; i++) begin
        res_cnt[i] <= 2'd0;
        rank[i]    <= VW'(NUM_VOICES - 1 - i);
      end
    end else begin
      voice_load    <= pick_onehot;
      note_stolen   <= pick_vld && !has_free;
      note_dropped  <= load_new_note && !pick_vld;
      active_voices <= AW'($countones(busy));
      if (pick_vld) begin
        voice_note     <= note_to_load;
        voice_duration <= duration_to_load;
      end
      for (int i = 0; i < NUM_VOICES; i++) begin
        if (pick_onehot[i]) begin
          res_cnt[i] <= 2'd3;
        end else if (voice_playing[i]) begin
          res_cnt[i] <= 2'd0;
        end else if (res_cnt[i] != 2'd0) begin
          res_cnt[i] <= res_cnt[i] - 2'd1;
        end
        // Loaded voice becomes newest; only voices younger than it age by one.
        if (pick_vld) begin
          if (VW'(i) == pick_idx) begin
            rank[i] <= '0;
          end else if (rank[i] < rank[pick_idx]) begin
            rank[i] <= rank[i] + VW'(1);
          end
        end
      end
    end
  end

  logic signed [ACC_W-1:0]  sum_c;
  logic signed [ACC_W-1:0]  sum_q;
  logic                     mix_vld;
  logic [SAMPLE_WIDTH-1:0]  mix_c;

  always_comb begin
    sum_c = '0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      sum_c = sum_c + {{VW{voice_sample[i*SAMPLE_WIDTH + SAMPLE_WIDTH - 1]}},
                       voice_sample[i*SAMPLE_WIDTH +: SAMPLE_WIDTH]};
    end
  end

  // The top SAMPLE_WIDTH bits of the accumulator are exactly the arithmetic shift by VW.
  always_comb begin
    mix_c = sum_q[VW +: SAMPLE_WIDTH];
    if (MIX_MODE != 0) begin
      if (sum_q > SAT_HI) begin
        mix_c = {1'b0, {(SAMPLE_WIDTH - 1){1'b1}}};
      end else if (sum_q < SAT_LO) begin
        mix_c = {1'b1, {(SAMPLE_WIDTH - 1){1'b0}}};
      end else begin
        mix_c = sum_q[SAMPLE_WIDTH-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sum_q            <= '0;
      mix_vld          <= 1'b0;
      sample_out       <= '0;
      new_sample_ready <= 1'b0;
    end else begin
      mix_vld          <= |voice_sample_ready;
      new_sample_ready <= mix_vld;
      if (|voice_sample_ready) begin
        sum_q <= sum_c;
      end
      if (mix_vld) begin
        sample_out <= mix_c;
      end
    end
  end

endmodule

// File: tb/tb_poly_voice_manager.sv
// Bench for poly_voice_manager: instance 0 steals with shift mixing, instance 1 drops with saturating mixing.
module tb_poly_voice_manager;
  localparam int N  = 4;
  localparam int SW = 16;
  localparam int NW = 6;
  localparam int DW = 6;
  localparam int L2 = 2;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            load_new_note;
  logic [NW-1:0]   note_to_load;
  logic [DW-1:0]   duration_to_load;
  logic [N-1:0]    voice_playing;
  logic [N*SW-1:0] voice_sample;
  logic [N-1:0]    voice_sample_ready;

  logic [N-1:0]  vl  [2];
  logic [NW-1:0] vn  [2];
  logic [DW-1:0] vd  [2];
  logic          st  [2];
  logic          dr  [2];
  logic [2:0]    av  [2];
  logic [SW-1:0] so  [2];
  logic          nsr [2];

  always #5 clk = ~clk;

  poly_voice_manager #(.NUM_VOICES(N), .SAMPLE_WIDTH(SW), .NOTE_WIDTH(NW), .DUR_WIDTH(DW),
                       .STEAL_ENABLE(1), .MIX_MODE(0)) dut_a (
    .clk(clk), .reset(reset), .load_new_note(load_new_note), .note_to_load(note_to_load),
    .duration_to_load(duration_to_load), .voice_playing(voice_playing), .voice_sample(voice_sample),
    .voice_sample_ready(voice_sample_ready), .voice_load(vl[0]), .voice_note(vn[0]),
    .voice_duration(vd[0]), .note_stolen(st[0]), .note_dropped(dr[0]), .active_voices(av[0]),
    .sample_out(so[0]), .new_sample_ready(nsr[0]));

  poly_voice_manager #(.NUM_VOICES(N), .SAMPLE_WIDTH(SW), .NOTE_WIDTH(NW), .DUR_WIDTH(DW),
                       .STEAL_ENABLE(0), .MIX_MODE(1)) dut_b (
    .clk(clk), .reset(reset), .load_new_note(load_new_note), .note_to_load(note_to_load),
    .duration_to_load(duration_to_load), .voice_playing(voice_playing), .voice_sample(voice_sample),
    .voice_sample_ready(voice_sample_ready), .voice_load(vl[1]), .voice_note(vn[1]),
    .voice_duration(vd[1]), .note_stolen(st[1]), .note_dropped(dr[1]), .active_voices(av[1]),
    .sample_out(so[1]), .new_sample_ready(nsr[1]));

  // Reference model: timestamps instead of ranks/counters, a due-cycle queue for the mixer.
  typedef struct { int due; int v0; int v1; } mix_t;
  mix_t mix_q[$];
  int   cyc;
  int   last_use  [2][N];
  int   strobe_at [2][N];
  bit   played    [2][N];

  logic [N-1:0]  e_load    [2];
  logic [NW-1:0] e_note    [2];
  logic [DW-1:0] e_dur     [2];
  bit            e_stolen  [2];
  bit            e_dropped [2];
  int            e_active  [2];
  logic [SW-1:0] e_sample  [2];
  bit            e_nsr;

  int n_vec = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  function automatic int clamp(input int s);
    if (s > (1 << (SW - 1)) - 1) return (1 << (SW - 1)) - 1;
    if (s < -(1 << (SW - 1))) return -(1 << (SW - 1));
    return s;
  endfunction

  task automatic model_reset();
    cyc = 0;
    mix_q.delete();
    e_nsr = 1'b0;
    for (int k = 0; k < 2; k++) begin
      e_load[k] = '0; e_note[k] = '0; e_dur[k] = '0;
      e_stolen[k] = 1'b0; e_dropped[k] = 1'b0; e_active[k] = 0; e_sample[k] = '0;
      for (int i = 0; i < N; i++) begin
        last_use[k][i]  = i - N;
        strobe_at[k][i] = -100;
        played[k][i]    = 1'b0;
      end
    end
  endtask

  // Advances the model across one rising edge using the inputs held before it.
  task automatic model_step();
    int v;
    int nb;
    int s;
    bit busy [N];
    for (int k = 0; k < 2; k++) begin
      v = -1;
      nb = 0;
      for (int i = 0; i < N; i++) begin
        busy[i] = voice_playing[i] || ((cyc - strobe_at[k][i] <= 2) && !played[k][i]);
        nb += int'(busy[i]);
      end
      e_load[k] = '0; e_stolen[k] = 1'b0; e_dropped[k] = 1'b0;
      if (load_new_note) begin
        for (int i = N - 1; i >= 0; i--) if (!busy[i]) v = i;
        if (v < 0) begin
          if (k == 0) begin
            v = 0;
            for (int i = 1; i < N; i++) if (last_use[k][i] < last_use[k][v]) v = i;
            e_stolen[k] = 1'b1;
          end else begin
            e_dropped[k] = 1'b1;
          end
        end
      end
      for (int i = 0; i < N; i++) played[k][i] = played[k][i] | voice_playing[i];
      if (v >= 0) begin
        e_load[k][v]    = 1'b1;
        e_note[k]       = note_to_load;
        e_dur[k]        = duration_to_load;
        last_use[k][v]  = cyc + 1;
        strobe_at[k][v] = cyc + 1;
        played[k][v]    = 1'b0;
      end
      e_active[k] = nb;
    end
    if (|voice_sample_ready) begin
      s = 0;
      for (int i = 0; i < N; i++) s += $signed(voice_sample[i*SW +: SW]);
      mix_q.push_back('{cyc + 2, s >>> L2, clamp(s)});
    end
    cyc++;
    e_nsr = 1'b0;
    if (mix_q.size() > 0 && mix_q[0].due == cyc) begin
      e_nsr = 1'b1;
      e_sample[0] = SW'(mix_q[0].v0);
      e_sample[1] = SW'(mix_q[0].v1);
      void'(mix_q.pop_front());
    end
  endtask

  task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] want);
    n_vec++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s dut%0d cyc=%0d got %0h want %0h", name, k, cyc, act, want);
    end
  endtask

  task automatic pin(input string name, input logic [31:0] act, input logic [31:0] want);
    chk(name, 9, act, want);
  endtask

  task automatic pin2(input string name, input logic [31:0] dut_val, input logic [31:0] mdl_val,
                      input logic [31:0] want);
    pin({name, "_dut"}, dut_val, want);
    pin({name, "_model"}, mdl_val, want);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < 2; k++) begin
        chk("voice_load", k, 32'(vl[k]), 32'(e_load[k]));
        chk("note_stolen", k, 32'(st[k]), 32'(e_stolen[k]));
        chk("note_dropped", k, 32'(dr[k]), 32'(e_dropped[k]));
        chk("active_voices", k, 32'(av[k]), e_active[k]);
        chk("new_sample_ready", k, 32'(nsr[k]), 32'(e_nsr));
        chk("sample_out", k, 32'(so[k]), 32'(e_sample[k]));
        if (e_load[k] != '0) begin
          chk("voice_note", k, 32'(vn[k]), 32'(e_note[k]));
          chk("voice_duration", k, 32'(vd[k]), 32'(e_dur[k]));
        end
      end
    end
  end

  task automatic idle_inputs();
    load_new_note = 1'b0; note_to_load = '0; duration_to_load = '0;
    voice_playing = '0; voice_sample = '0; voice_sample_ready = '0;
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic apply_reset();
    idle_inputs();
    reset = 1'b0;
    model_reset();
    chk_en = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  // Called just after a rising edge: reset drops mid-cycle and covers the next edge.
  task automatic mid_reset();
    #2;
    reset = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic req(input int note, input int dur, input logic [N-1:0] play);
    load_new_note = 1'b1;
    note_to_load = NW'(note);
    duration_to_load = DW'(dur);
    voice_playing = play;
    step();
    load_new_note = 1'b0;
  endtask

  task automatic set_samples(input logic [15:0] s0, input logic [15:0] s1,
                             input logic [15:0] s2, input logic [15:0] s3);
    voice_sample = {s3, s2, s1, s0};
  endtask

  initial begin
    idle_inputs();
    #1;
    apply_reset();
    pin2("rst_active", 32'(av[0]), e_active[0], 0);
    pin2("rst_sample", 32'(so[1]), 32'(e_sample[1]), 0);

    req(12, 8, 4'b0000);
    pin2("first_load", 32'(vl[0]), 32'(e_load[0]), 32'b0001);
    pin2("first_note", 32'(vn[0]), 32'(e_note[0]), 12);
    pin2("first_dur", 32'(vd[0]), 32'(e_dur[0]), 8);
    pin("first_stolen", 32'(st[0]), 0);
    pin("first_dropped", 32'(dr[1]), 0);

    apply_reset();
    for (int r = 0; r < 4; r++) begin
      req(r + 1, r + 2, 4'b0000);
      pin2("b2b_load", 32'(vl[0]), 32'(e_load[0]), 32'(1 << r));
    end
    req(5, 6, 4'b0000);
    pin2("expired_reuse", 32'(vl[1]), 32'(e_load[1]), 32'b0001);
    pin("expired_no_steal", 32'(st[0]), 0);
    voice_playing = '0;
    repeat (5) step();
    pin2("expired_active", 32'(av[0]), e_active[0], 0);

    apply_reset();
    req(7, 7, 4'b1111);
    pin2("rst_lru_steal", 32'(vl[0]), 32'(e_load[0]), 32'b0001);
    pin("rst_lru_stolen", 32'(st[0]), 1);

    apply_reset();
    req(1, 1, 4'b0011);
    pin("lru_seq0", 32'(vl[0]), 32'b0100);
    req(2, 2, 4'b0010);
    pin("lru_seq1", 32'(vl[0]), 32'b0001);
    req(3, 3, 4'b0010);
    pin("lru_seq2", 32'(vl[0]), 32'b1000);
    req(4, 4, 4'b0000);
    pin("lru_seq3", 32'(vl[0]), 32'b0010);
    req(9, 9, 4'b1111);
    pin2("steal_load", 32'(vl[0]), 32'(e_load[0]), 32'b0100);
    pin2("steal_flag", 32'(st[0]), 32'(e_stolen[0]), 1);
    pin2("drop_flag", 32'(dr[1]), 32'(e_dropped[1]), 1);
    pin2("drop_load", 32'(vl[1]), 32'(e_load[1]), 0);

    apply_reset();
    set_samples(16'h4000, 16'h4000, 16'h4000, 16'h4000);
    voice_sample_ready = 4'b0001;
    step();
    voice_sample_ready = 4'b0000;
    step();
    pin2("mix_shift", 32'(so[0]), 32'(e_sample[0]), 32'h4000);
    pin2("mix_ready", 32'(nsr[0]), 32'(e_nsr), 1);
    pin("mix_sat_full", 32'(so[1]), 32'h7FFF);
    set_samples(16'h7000, 16'h7000, 16'h0000, 16'h0000);
    voice_sample_ready = 4'b0010;
    step();
    set_samples(16'h9000, 16'h9000, 16'h0000, 16'h0000);
    voice_sample_ready = 4'b1000;
    step();
    pin2("sat_pos", 32'(so[1]), 32'(e_sample[1]), 32'h7FFF);
    pin("shift_pos", 32'(so[0]), 32'h3800);
    voice_sample_ready = 4'b0000;
    step();
    pin2("sat_neg", 32'(so[1]), 32'(e_sample[1]), 32'h8000);
    pin("shift_neg", 32'(so[0]), 32'hC800);
    pin("b2b_ready", 32'(nsr[1]), 1);
    step();
    pin("hold_sample", 32'(so[0]), 32'hC800);

    set_samples(16'h1234, 16'h1234, 16'h1234, 16'h1234);
    voice_sample_ready = 4'b1111;
    voice_playing = 4'b0110;
    step();
    voice_sample_ready = 4'b0000;
    load_new_note = 1'b1;
    mid_reset();
    idle_inputs();
    pin("abort_load_now", 32'(vl[0]), 0);
    step();
    step();
    pin2("abort_load", 32'(vl[0]), 32'(e_load[0]), 0);
    pin2("abort_sample", 32'(so[0]), 32'(e_sample[0]), 0);
    pin2("abort_active", 32'(av[1]), e_active[1], 0);

    for (int c = 0; c < 3000; c++) begin
      load_new_note = 1'($urandom_range(0, 1));
      note_to_load = NW'($urandom);
      duration_to_load = DW'($urandom);
      voice_playing = ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom & $urandom);
      voice_sample = {$urandom, $urandom};
      voice_sample_ready = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom);
      if (c % 700 == 350) mid_reset();
      else step();
    end

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired before the bench finished");
    $fatal(1);
  end

endmodule

// File: doc/poly_voice_manager.md
# poly_voice_manager

Parametrised polyphonic voice allocator and mixer for the music player. It takes the note stream from the song reader and hands each note to one of NUM_VOICES external `note_player` instances through one-hot load strobes. When every voice is busy it either steals the least-recently-loaded voice or drops the note. It mixes the voice samples into one codec sample with selectable headroom or saturation.

## Interface
- NUM_VOICES, 4: voice count, 2..8.
- SAMPLE_WIDTH, 16: signed sample width.
- NOTE_WIDTH, 6: note code width.
- DUR_WIDTH, 6: duration width.
- STEAL_ENABLE, 1: 1 = steal LRU voice when all busy; 0 = drop note.
- MIX_MODE, 0: 0 = arithmetic shift right by clog2(NUM_VOICES); 1 = no shift, saturate.
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- load_new_note  in  1  one-cycle note request.
- note_to_load  in  NOTE_WIDTH  note, sampled with load_new_note.
- duration_to_load  in  DUR_WIDTH  duration, sampled with load_new_note.
- voice_playing  in  NUM_VOICES  per-voice playing flags.
- voice_sample  in  NUM_VOICES*SAMPLE_WIDTH  signed samples; voice i at [i*SAMPLE_WIDTH +: SAMPLE_WIDTH].
- voice_sample_ready  in  NUM_VOICES  per-voice sample strobes.
- voice_load  out  NUM_VOICES  one-hot load strobe, one cycle.
- voice_note  out  NOTE_WIDTH  registered note; valid while voice_load != 0.
- voice_duration  out  DUR_WIDTH  registered duration; valid while voice_load != 0.
- note_stolen  out  1  pulse: load went to a stolen voice.
- note_dropped  out  1  pulse: request discarded.
- active_voices  out  clog2(NUM_VOICES+1)  popcount of (voice_playing | reserved), registered.
- sample_out  out  SAMPLE_WIDTH  signed mixed sample.
- new_sample_ready  out  1  sample_out valid strobe.

## Operation
- Busy[i] = voice_playing[i] | reserved[i].
- Reserved[i]:
  - Set in the cycle voice_load[i] asserts.
  - Cleared on the first cycle voice_playing[i]=1, or after 3 cycles with no voice_playing[i].
- Allocation on load_new_note at cycle t:
  - The lowest-index non-busy voice v is chosen.
  - voice_load[v], voice_note and voice_duration are driven at t+1.
- All voices busy:
  - STEAL_ENABLE=1: choose voice with rank NUM_VOICES-1 (LRU); pulse voice_load and note_stolen at t+1.
  - STEAL_ENABLE=0: pulse note_dropped at t+1; voice_load stays 0.
- LRU ranks, one per voice, 0..NUM_VOICES-1, always a permutation:
  - Reset value: rank[i] = NUM_VOICES-1-i, so voice 0 is oldest.
  - On load of voice v, rank[v] goes to 0 and every voice whose rank was below old rank[v] increments.
- Back-to-back requests are legal every cycle. The voice strobed in the previous cycle is already busy through reserved.
- Mixer stage 1: on any voice_sample_ready bit, sign-extend all NUM_VOICES samples to SAMPLE_WIDTH+clog2(NUM_VOICES) bits, sum them and register the sum.
- Mixer stage 2:
  - MIX_MODE 0: arithmetic shift right by clog2(NUM_VOICES).
  - MIX_MODE 1: clamp to [-2^(SAMPLE_WIDTH-1), 2^(SAMPLE_WIDTH-1)-1].
  - The result is registered into sample_out.
- Idle voices add whatever sample they present; the players output 0 when idle.

## Timing
- Reset (asynchronous, active-low) sets all outputs to 0, reserved to 0 and ranks to their reset values.
- Reset mid-operation aborts any pending strobe; no voice_load follows deassertion.
- Allocation latency is 1 cycle from load_new_note to voice_load, note_stolen or note_dropped.
- Mixer latency is 2 cycles: voice_sample_ready at s gives new_sample_ready at s+2, a one-cycle pulse.
- Ready strobes on consecutive cycles produce consecutive output pulses; the mixer is fully pipelined.
- sample_out holds its value between strobes.
- active_voices lags its inputs by 1 cycle.
- Exactly one of voice_load (non-zero), note_dropped or note_stolen-with-load fires per request.

## Test plan
- Reset, all voices idle, one request note=12, dur=8 -> next cycle voice_load=0001, voice_note=12, voice_duration=8; no stolen or dropped pulse.
- Four requests on consecutive cycles, voice_playing held 0 -> voice_load sequence 0001, 0010, 0100, 1000; reserved blocks reuse; all reserved bits expire 3 cycles after each strobe.
- voice_playing=1111, loads previously issued to voices 2,0,3,1 in that order, one request -> voice_load=0100 and note_stolen=1. With STEAL_ENABLE=0 the same stimulus gives note_dropped=1 and voice_load=0000.
- MIX_MODE 0, NUM_VOICES=4, samples 0x4000, 0x4000, 0x4000, 0x4000 with voice_sample_ready=0001 -> two cycles later sample_out=0x4000 and new_sample_ready=1.
- MIX_MODE 1, samples 0x7000, 0x7000, 0, 0 -> sample_out=0x7FFF. Samples 0x9000, 0x9000, 0, 0 -> sample_out=0x8000.
- Assert reset for one cycle between load_new_note and its strobe -> voice_load stays 0, sample_out=0, active_voices=0.
